// File: rtl/svm_data_fetch.sv
// svm_data_fetch: snapshots the dataset geometry on start and streams tagged
// point words from memory through a credit-limited, in-order return FIFO.
module svm_data_fetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int EPOCH_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cfg_done,
    input  logic [31:0]        train_data_base,
    input  logic [31:0]        num_dim,
    input  logic [31:0]        num_data_points,
    input  logic [31:0]        num_test_points,
    input  logic [EPOCH_W-1:0] num_epochs,
    output logic               mem_rd_req,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic               mem_rd_gnt,
    input  logic               mem_rd_vld,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               pt_vld,
    input  logic               pt_rdy,
    output logic [DATA_W-1:0]  pt_data,
    output logic               pt_is_label,
    output logic               pt_is_test,
    output logic [EPOCH_W-1:0] pt_epoch,
    output logic               busy,
    output logic               batch_comp_done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = EPOCH_W + 2;
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH;
    localparam logic [1:0] S_IDLE = 2'd0, S_TRAIN = 2'd1, S_TEST = 2'd2, S_DRAIN = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d, addr_q, addr_d;
    logic [31:0]          dim_q, dim_d, ntrain_q, ntrain_d, ntest_q, ntest_d;
    logic [31:0]          dim_cnt_q, dim_cnt_d, pt_cnt_q, pt_cnt_d;
    logic [EPOCH_W-1:0]   elast_q, elast_d, epoch_cnt_q, epoch_cnt_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        tag_cnt_q, tag_cnt_d, ret_cnt_q, ret_cnt_d;
    logic [PW-1:0]        tag_wp_q, tag_rp_q, ret_wp_q, ret_rp_q;
    logic [TW-1:0]        tag_mem [FIFO_DEPTH];
    logic [DATA_W+TW-1:0] ret_mem [FIFO_DEPTH];
    logic [31:0]          tprime, pt_lim;
    logic [CW:0]          inflight;
    logic [TW-1:0]        tag_in;
    logic                 accept, issuing, grant, rvld, pop, last_dim, pt_last, ep_last;

    assign tprime      = (num_test_points > num_data_points) ? num_data_points : num_test_points;
    assign accept      = start && cfg_done && state_q == S_IDLE;
    assign issuing     = state_q == S_TRAIN || state_q == S_TEST;
    // Tags in flight plus buffered words bound the return FIFO occupancy.
    assign inflight    = {1'b0, tag_cnt_q} + {1'b0, ret_cnt_q};
    assign mem_rd_req  = issuing && inflight < DEPTH_C;
    assign grant       = mem_rd_req && mem_rd_gnt;
    assign rvld        = mem_rd_vld && tag_cnt_q != '0;
    assign pt_vld      = ret_cnt_q != '0;
    assign pop         = pt_vld && pt_rdy;
    assign last_dim    = dim_cnt_q == dim_q;
    assign pt_lim      = (state_q == S_TEST) ? ntest_q : ntrain_q;
    assign pt_last     = pt_cnt_q == pt_lim - 32'd1;
    assign ep_last     = epoch_cnt_q == elast_q;
    assign tag_in      = {last_dim, state_q == S_TEST, (state_q == S_TEST) ? elast_q : epoch_cnt_q};
    assign {pt_data, pt_is_label, pt_is_test, pt_epoch} = pt_vld ? ret_mem[ret_rp_q] : '0;
    assign mem_rd_addr = addr_q;
    assign busy        = state_q != S_IDLE;
    assign batch_comp_done = done_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        dim_d       = dim_q;
        ntrain_d    = ntrain_q;
        ntest_d     = ntest_q;
        elast_d     = elast_q;
        dim_cnt_d   = dim_cnt_q;
        pt_cnt_d    = pt_cnt_q;
        epoch_cnt_d = epoch_cnt_q;
        done_d      = done_q;
        tag_cnt_d   = tag_cnt_q + CW'(grant) - CW'(rvld);
        ret_cnt_d   = ret_cnt_q + CW'(rvld) - CW'(pop);
        if (accept) begin
            base_d      = ADDR_W'(train_data_base);
            addr_d      = ADDR_W'(train_data_base);
            dim_d       = num_dim;
            ntrain_d    = num_data_points - tprime;
            ntest_d     = tprime;
            elast_d     = (num_epochs == '0) ? '0 : num_epochs - EPOCH_W'(1);
            dim_cnt_d   = '0;
            pt_cnt_d    = '0;
            epoch_cnt_d = '0;
            done_d      = 1'b0;
            state_d     = (num_data_points == 32'd0) ? S_DRAIN :
                          (tprime == num_data_points) ? S_TEST : S_TRAIN;
        end
        if (grant) begin
            dim_cnt_d = last_dim ? '0 : dim_cnt_q + 32'd1;
            addr_d    = addr_q + ADDR_W'(1);
            if (last_dim) begin
                pt_cnt_d = pt_last ? '0 : pt_cnt_q + 32'd1;
                if (pt_last && state_q == S_TEST)
                    state_d = S_DRAIN;
                // The final training pass runs straight on into the test points.
                if (pt_last && state_q == S_TRAIN) begin
                    if (ep_last) begin
                        state_d = (ntest_q == '0) ? S_DRAIN : S_TEST;
                    end else begin
                        epoch_cnt_d = epoch_cnt_q + EPOCH_W'(1);
                        addr_d      = base_q;
                    end
                end
            end
        end
        if (state_q == S_DRAIN && tag_cnt_d == '0 && ret_cnt_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            dim_q       <= '0;
            ntrain_q    <= '0;
            ntest_q     <= '0;
            elast_q     <= '0;
            dim_cnt_q   <= '0;
            pt_cnt_q    <= '0;
            epoch_cnt_q <= '0;
            done_q      <= 1'b0;
            tag_cnt_q   <= '0;
            ret_cnt_q   <= '0;
            tag_wp_q    <= '0;
            tag_rp_q    <= '0;
            ret_wp_q    <= '0;
            ret_rp_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            dim_q       <= dim_d;
            ntrain_q    <= ntrain_d;
            ntest_q     <= ntest_d;
            elast_q     <= elast_d;
            dim_cnt_q   <= dim_cnt_d;
            pt_cnt_q    <= pt_cnt_d;
            epoch_cnt_q <= epoch_cnt_d;
            done_q      <= done_d;
            tag_cnt_q   <= tag_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            if (grant) tag_wp_q <= tag_wp_q + PW'(1);
            if (rvld) tag_rp_q <= tag_rp_q + PW'(1);
            if (rvld) ret_wp_q <= ret_wp_q + PW'(1);
            if (pop) ret_rp_q <= ret_rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) tag_mem[tag_wp_q] <= tag_in;
        if (rvld) ret_mem[ret_wp_q] <= {mem_rd_data, tag_mem[tag_rp_q]};
    end
endmodule
